// File: rtl/vx_tag_reorder.sv
// Tag reorder buffer: hands out tags in order, accepts responses in any order,
// and retires payloads strictly in allocation order.
module vx_tag_reorder #(
  parameter int unsigned DATAW = 1,
  parameter int unsigned SIZE  = 4,
  localparam int unsigned TAGW = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int unsigned CNTW = TAGW + 1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [TAGW-1:0]  alloc_tag,

  input  logic             rsp_valid,
  input  logic [TAGW-1:0]  rsp_tag,
  input  logic [DATAW-1:0] rsp_data,

  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,

  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [CNTW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [SIZE-1:0]  done_q, done_d;
  logic [DATAW-1:0] entries [SIZE];

  logic [TAGW-1:0] rd_slot;
  logic [TAGW-1:0] wr_slot;
  logic            alloc_fire;
  logic            retire_fire;

  assign rd_slot = rd_ptr_q[TAGW-1:0];
  assign wr_slot = wr_ptr_q[TAGW-1:0];

  // MSB distinguishes a full ring from an empty one when slot indices match.
  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_slot == wr_slot) && (rd_ptr_q[CNTW-1] != wr_ptr_q[CNTW-1]);

  assign alloc_ready = !full;
  assign alloc_tag   = wr_slot;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Head readiness comes only from registered state; no bypass from the rsp port.
  assign out_valid   = !empty && done_q[rd_slot];
  assign out_data    = entries[rd_slot];
  assign retire_fire = out_valid && out_ready;

  assign count = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    done_d   = done_q;

    if (alloc_fire) begin
      done_d[wr_slot] = 1'b0;
      wr_ptr_d        = wr_ptr_q + CNTW'(1);
    end
    if (retire_fire) begin
      done_d[rd_slot] = 1'b0;
      rd_ptr_d        = rd_ptr_q + CNTW'(1);
    end
    if (rsp_valid) begin
      done_d[rsp_tag] = 1'b1;
    end

    unique case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (rsp_valid) begin
      entries[rsp_tag] <= rsp_data;
    end
  end

`ifndef SYNTHESIS
  logic [TAGW-1:0] rsp_offset;
  logic            rsp_in_flight;

  assign rsp_offset    = rsp_tag - rd_slot;
  assign rsp_in_flight = (CNTW'(rsp_offset) < count_q);

  always_ff @(posedge clk) begin
    if (reset && rsp_valid) begin
      assert (rsp_in_flight && !done_q[rsp_tag])
        else $error("vx_tag_reorder: rsp_tag %0d not allocated or already done", rsp_tag);
      assert (!(retire_fire && (rsp_tag == rd_slot)))
        else $error("vx_tag_reorder: response to head slot during retire");
    end
  end
`endif

endmodule

// File: doc/vx_tag_reorder.md
VX_TAG_REORDER -- requirements
Module: VX_tag_reorder

Interface
REQ-001 SHALL have parameter DATAW, default 1, response payload width in bits.
REQ-002 SHALL have parameter SIZE, default 4, number of tag slots; power of two, >= 2.
REQ-003 SHALL derive TAGW = LOG2UP(SIZE) and CNTW = LOG2UP(SIZE)+1 as localparams.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port alloc_valid  input  1  request for a new tag.
REQ-007 SHALL have port alloc_ready  output  1  a tag slot is free.
REQ-008 SHALL have port alloc_tag  output  TAGW  tag granted on alloc fire.
REQ-009 SHALL have port rsp_valid  input  1  out-of-order response arrival; always accepted.
REQ-010 SHALL have port rsp_tag  input  TAGW  slot the response belongs to.
REQ-011 SHALL have port rsp_data  input  DATAW  response payload.
REQ-012 SHALL have port out_valid  output  1  head response ready to retire.
REQ-013 SHALL have port out_data  output  DATAW  head response payload.
REQ-014 SHALL have port out_ready  input  1  consumer accepts head.
REQ-015 SHALL have port count  output  CNTW  number of allocated, unretired tags.
REQ-016 SHALL have ports full and empty, output, 1 bit each.

Function
REQ-017 SHALL keep rd_ptr and wr_ptr of CNTW bits; slot index = low TAGW bits; wrap-around via MSB.
REQ-018 SHALL assert empty when rd_ptr == wr_ptr; full when low bits equal and MSBs differ.
REQ-019 SHALL drive alloc_ready = !full and alloc_tag = wr_ptr low bits, combinationally.
REQ-020 SHALL on alloc fire (alloc_valid & alloc_ready) clear done[alloc_tag] and increment wr_ptr.
REQ-021 SHALL on rsp_valid write rsp_data to entries[rsp_tag] and set done[rsp_tag].
REQ-022 SHALL drive out_valid = !empty & done[rd_ptr slot], out_data = entries[rd_ptr slot], with no bypass from rsp inputs.
REQ-023 SHALL therefore show out_valid no earlier than the cycle after the head's rsp_valid.
REQ-024 SHALL on retire fire (out_valid & out_ready) clear done at the head and increment rd_ptr.
REQ-025 SHALL retire strictly in allocation order regardless of response order.
REQ-026 SHALL update count +1 on alloc only, -1 on retire only, unchanged on both or neither.
REQ-027 SHALL NOT accept alloc in the same cycle a retire frees the last slot when full (alloc_ready stays low that cycle).
REQ-028 SHALL allow alloc, rsp and retire in the same cycle when they target distinct slots.
REQ-029 SHALL runtime-assert that rsp_tag addresses an allocated, not-yet-done slot.
REQ-030 SHALL runtime-assert that a retire fire never coincides with rsp_valid to the head slot.
REQ-031 SHALL leave out_data undefined while out_valid is low; payload RAM SHALL NOT be reset.

Reset
REQ-032 SHALL, while reset is low, asynchronously clear rd_ptr, wr_ptr and all done bits.
REQ-033 SHALL hold after reset: empty=1, full=0, alloc_ready=1, alloc_tag=0, out_valid=0, count=0.
REQ-034 SHALL on reset mid-operation discard all outstanding tags and pending responses; first post-reset alloc_tag=0.

Verification (SIZE=4, DATAW=8)
REQ-035 SHALL cover in-order: alloc tags 0,1; rsp 0=0xA0, 1=0xA1; out_ready=1 -> retire 0xA0 then 0xA1, count 2->0.
REQ-036 SHALL cover reorder: alloc 0,1,2; rsp 2=0x22, 1=0x11 -> out_valid=0; then rsp 0=0x00 next cycle -> retire 0x00,0x11,0x22 on three consecutive cycles.
REQ-037 SHALL cover full: 4 allocs -> full=1, alloc_ready=0, count=4; retire head while alloc_valid=1 -> no alloc that cycle, alloc_tag=0 granted next cycle.
REQ-038 SHALL cover wrap: 6 alloc/rsp/retire cycles -> alloc_tag sequence 0,1,2,3,0,1, empty=1 at end.
REQ-039 SHALL cover backpressure: head done, out_ready=0 for 3 cycles -> out_valid and out_data held stable, count unchanged.
REQ-040 SHALL cover reset mid-flight: 3 tags allocated, 1 done, reset low one cycle -> all outputs at REQ-033 values immediately.
